// File: rtl/procesador_pkg.sv
// procesador_pkg: address width, sequential fetch step and fetch-stage state encoding.
package procesador_pkg;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;
    typedef enum logic {IDLE, REQ} estado_t;
endpackage

// File: rtl/sumador_pc.sv
// sumador_pc: combinational PC incrementer, wraps modulo 2^ADDR_W.
module sumador_pc
    import procesador_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STEP = procesador_pkg::PC_STEP
) (
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_mas4
);
    assign pc_mas4 = pc + STEP;
endmodule

// File: rtl/contador_programa.sv
// contador_programa: program counter and fetch request handshake with branch redirect.
// PC_ALIGN_CHECK_EN rejects misaligned redirect targets and raises the sticky pc_error.
module contador_programa
    import procesador_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] PC_STEP    = procesador_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              salto_tomado,
    input  logic [ADDR_W-1:0] result_suma,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] bus_direccion_im,
    output logic              im_valid,
    output logic [ADDR_W-1:0] pc_mas4,
    output logic              pc_error
);
    estado_t           state, state_next;
    logic [ADDR_W-1:0] pc_next, pend_addr, pend_addr_next;
    logic              pend_valid, pend_valid_next, handshake, target_ok;

    sumador_pc #(.STEP(PC_STEP)) u_sumador (
        .pc      (bus_direccion_im),
        .pc_mas4 (pc_mas4)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign target_ok = salto_tomado & (result_suma[1:0] == 2'b00);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pc_error <= 1'b0;
        else if (salto_tomado && result_suma[1:0] != 2'b00) pc_error <= 1'b1;
`else
    assign target_ok = salto_tomado;
    assign pc_error  = 1'b0;
`endif

    assign im_valid  = (state == REQ);
    assign handshake = im_valid & im_ready;

    always_comb begin
        state_next      = state;
        pc_next         = bus_direccion_im;
        pend_addr_next  = pend_addr;
        pend_valid_next = pend_valid;
        if (state == IDLE) begin
            pc_next    = target_ok ? result_suma : bus_direccion_im;
            state_next = stall ? IDLE : REQ;
        end else if (handshake) begin
            pc_next         = target_ok ? result_suma : pend_valid ? pend_addr : pc_mas4;
            pend_valid_next = 1'b0;
            state_next      = stall ? IDLE : REQ;
        end else if (target_ok) begin
            // request outstanding: address must stay frozen, so park the target
            pend_addr_next  = result_suma;
            pend_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state            <= IDLE;
            bus_direccion_im <= RESET_ADDR;
            pend_addr        <= '0;
            pend_valid       <= 1'b0;
        end else begin
            state            <= state_next;
            bus_direccion_im <= pc_next;
            pend_addr        <= pend_addr_next;
            pend_valid       <= pend_valid_next;
        end
endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa: directed plus random fetch traffic against a transaction-level PC model.
module tb_contador_programa;
    localparam logic [63:0] RESET_ADDR = 64'h0;
    localparam logic [63:0] PC_STEP    = 64'd4;

    logic        clk = 1'b0;
    logic        reset_n, stall, salto_tomado, im_ready;
    logic [63:0] result_suma, bus_direccion_im, pc_mas4;
    logic        im_valid, pc_error;

    contador_programa #(.RESET_ADDR(RESET_ADDR), .PC_STEP(PC_STEP)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .salto_tomado     (salto_tomado),
        .result_suma      (result_suma),
        .im_ready         (im_ready),
        .bus_direccion_im (bus_direccion_im),
        .im_valid         (im_valid),
        .pc_mas4          (pc_mas4),
        .pc_error         (pc_error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] m_pend[$];
    logic [63:0] m_pc = RESET_ADDR;
    logic        m_req = 1'b0, m_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_ADDR;
        m_req = 1'b0;
        m_err = 1'b0;
        m_pend.delete();
        sb.delete();
    endtask

    // One clock of the fetch stage described as: who is fetching, and what address comes next.
    task automatic model_step(input logic s, input logic b, input logic [63:0] t, input logic r);
        logic ok;
        ok = b;
`ifdef PC_ALIGN_CHECK_EN
        if (b && t[1:0] != 2'b00) begin
            ok = 1'b0;
            m_err = 1'b1;
        end
`endif
        if (!m_req) begin
            if (ok) m_pc = t;
            m_req = !s;
        end else if (r) begin
            m_pc = ok ? t : (m_pend.size() > 0) ? m_pend[0] : m_pc + PC_STEP;
            m_pend.delete();
            m_req = !s;
        end else if (ok) begin
            m_pend.delete();
            m_pend.push_back(t);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [63:0] t, input logic r);
        stall = s;
        salto_tomado = b;
        result_suma = t;
        im_ready = r;
        if (m_req && r) sb.push_back(m_pc);
        @(posedge clk);
        #1;
        model_step(s, b, t, r);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("im_valid", {63'b0, im_valid}, {63'b0, m_req});
                chk("pc_mas4", pc_mas4, m_pc + PC_STEP);
                chk("pc_error", {63'b0, pc_error}, {63'b0, m_err});
                if (m_req) chk("bus_direccion_im", bus_direccion_im, m_pc);
                if (im_valid && im_ready) begin
                    if (sb.size() == 0) chk("sb_underflow", bus_direccion_im, 64'hx);
                    else chk("fetch_addr", bus_direccion_im, sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        stall = 1'b0;
        salto_tomado = 1'b0;
        result_suma = '0;
        im_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {63'b0, im_valid}, 64'd0);
        chk("reset_pc", bus_direccion_im, RESET_ADDR);
        reset_n = 1'b1;
        repeat (5) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1);
        step(0, 1, 64'h400, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 64'h402, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 1, 64'h800, 0);
        step(0, 1, 64'h900, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", {63'b0, im_valid}, 64'd0);
        chk("async_reset_pc", bus_direccion_im, RESET_ADDR);
        chk("async_reset_err", {63'b0, pc_error}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t, $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
